// File: rtl/exu_pkg.sv
// Shared ALU-issue types: one-hot opcode layout and the request/writeback records
// exchanged between issue, the ALU arbiter and the GPR writeback bus.
package exu_pkg;

  localparam int ALU_OP_WIDTH = 14;
  localparam int DATA_WIDTH   = 64;
  localparam int TAG_WIDTH    = 6;
  localparam int NUM_REQ      = 2;
  localparam int ID_WIDTH     = $clog2(NUM_REQ);

  // One-hot opcode bit positions
  localparam int ALU_ADD   = 0;
  localparam int ALU_SUB   = 1;
  localparam int ALU_AND   = 2;
  localparam int ALU_OR    = 3;
  localparam int ALU_XOR   = 4;
  localparam int ALU_SLL   = 5;
  localparam int ALU_SRL   = 6;
  localparam int ALU_SRA   = 7;
  localparam int ALU_SLT   = 8;
  localparam int ALU_SLTU  = 9;
  localparam int ALU_MIN   = 10;
  localparam int ALU_MAX   = 11;
  localparam int ALU_AUIPC = 12;
  localparam int ALU_LUI   = 13;

  typedef struct packed {
    logic [ALU_OP_WIDTH-1:0] op;
    logic [DATA_WIDTH-1:0]   src0;
    logic [DATA_WIDTH-1:0]   src1;
    logic [TAG_WIDTH-1:0]    tag;
  } alu_req_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } alu_wb_t;

endpackage

// File: rtl/exu_alu_arb_rr.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr_i,
// wrapping to the lowest-index requester when none sit at or above the pointer.
module arb_rr #(
  parameter int N  = 2,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o
);

  logic [N-1:0] mask;
  logic [N-1:0] masked;

  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign mask[gi] = (PW'(gi) >= ptr_i);
  end

  assign masked = req_i & mask;

  // x & -x isolates the lowest set bit
  assign grant_o = (|masked) ? (masked & (~masked + 1'b1))
                             : (req_i & (~req_i + 1'b1));

endmodule

// File: rtl/exu_alu_arb.sv
// Shares one registered-input ALU between NUM_REQ issue ports: round-robin issue,
// one-cycle result capture stage and a 2-entry credit-protected writeback queue.
module exu_alu_arb #(
  parameter int NUM_REQ      = 2,
  parameter int TAG_WIDTH    = exu_pkg::TAG_WIDTH,
  parameter int ALU_OP_WIDTH = exu_pkg::ALU_OP_WIDTH,
  parameter int DATA_WIDTH   = exu_pkg::DATA_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*ALU_OP_WIDTH-1:0]   req_op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_src0,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_src1,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]      req_tag,
  output logic [ALU_OP_WIDTH-1:0]           alu_op,
  output logic [DATA_WIDTH-1:0]             alu_src0,
  output logic [DATA_WIDTH-1:0]             alu_src1,
  input  logic [DATA_WIDTH-1:0]             alu_result,
  output logic                              wb_valid,
  input  logic                              wb_ready,
  output logic [$clog2(NUM_REQ)-1:0]        wb_id,
  output logic [TAG_WIDTH-1:0]              wb_tag,
  output logic [DATA_WIDTH-1:0]             wb_data
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef struct packed {
    logic [IDW-1:0]        id;
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } wb_ent_t;

  logic [ALU_OP_WIDTH-1:0] op_arr   [NUM_REQ];
  logic [DATA_WIDTH-1:0]   src0_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0]   src1_arr [NUM_REQ];
  logic [TAG_WIDTH-1:0]    tag_arr  [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
    assign op_arr[gi]   = req_op[gi*ALU_OP_WIDTH +: ALU_OP_WIDTH];
    assign src0_arr[gi] = req_src0[gi*DATA_WIDTH +: DATA_WIDTH];
    assign src1_arr[gi] = req_src1[gi*DATA_WIDTH +: DATA_WIDTH];
    assign tag_arr[gi]  = req_tag[gi*TAG_WIDTH +: TAG_WIDTH];

    a_onehot_op: assert property (@(posedge clk) disable iff (rst)
      req_valid[gi] |-> $onehot(op_arr[gi]));
  end

  logic [NUM_REQ-1:0]   grant;
  logic [IDW-1:0]       gnt_idx;
  logic [IDW-1:0]       rr_q, rr_d;
  logic                 s1_valid_q, s1_valid_d;
  logic [IDW-1:0]       s1_id_q;
  logic [TAG_WIDTH-1:0] s1_tag_q;
  wb_ent_t              q_mem_q [2];
  logic [1:0]           q_count_q, q_count_d;
  logic                 q_rd_q, q_rd_d;
  logic                 q_wr_q, q_wr_d;
  logic [2:0]           occ;
  logic                 can_issue, transfer, push, pop;

  arb_rr #(.N(NUM_REQ), .PW(IDW)) u_arb (
    .req_i   (req_valid),
    .ptr_i   (rr_q),
    .grant_o (grant)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) gnt_idx = IDW'(i);
    end
  end

  assign wb_valid = (q_count_q != 2'd0);
  assign pop      = wb_valid & wb_ready;
  assign push     = s1_valid_q;

  // Credit counts the s1 slot as already owning a queue entry; a same-cycle pop frees one.
  assign occ       = {1'b0, q_count_q} + {2'b00, s1_valid_q} - {2'b00, pop};
  assign can_issue = !rst && !flush && (occ < 3'd2);
  assign transfer  = can_issue && (|req_valid);
  assign req_ready = can_issue ? grant : '0;

  assign alu_op   = transfer ? op_arr[gnt_idx]   : '0;
  assign alu_src0 = transfer ? src0_arr[gnt_idx] : '0;
  assign alu_src1 = transfer ? src1_arr[gnt_idx] : '0;

  always_comb begin
    rr_d = rr_q;
    if (transfer) begin
      rr_d = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
    s1_valid_d = transfer;
    q_count_d  = flush ? 2'd0 : q_count_q + {1'b0, push} - {1'b0, pop};
    q_rd_d     = flush ? 1'b0 : q_rd_q ^ pop;
    q_wr_d     = flush ? 1'b0 : q_wr_q ^ push;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q       <= '0;
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s1_tag_q   <= '0;
      q_count_q  <= 2'd0;
      q_rd_q     <= 1'b0;
      q_wr_q     <= 1'b0;
      for (int i = 0; i < 2; i++) q_mem_q[i] <= '0;
    end else begin
      rr_q       <= rr_d;
      s1_valid_q <= s1_valid_d;
      q_count_q  <= q_count_d;
      q_rd_q     <= q_rd_d;
      q_wr_q     <= q_wr_d;
      if (transfer) begin
        s1_id_q  <= gnt_idx;
        s1_tag_q <= tag_arr[gnt_idx];
      end
      if (push && !flush) begin
        q_mem_q[q_wr_q] <= '{id: s1_id_q, tag: s1_tag_q, data: alu_result};
      end
    end
  end

  assign wb_id   = q_mem_q[q_rd_q].id;
  assign wb_tag  = q_mem_q[q_rd_q].tag;
  assign wb_data = q_mem_q[q_rd_q].data;

endmodule

// File: tb/tb_exu_alu_arb.sv
// Bench for exu_alu_arb: directed vector table, flush/reset sequences and random
// traffic, all checked against a queue-based model; the bench also plays the ALU.
module tb_exu_alu_arb;
  import exu_pkg::*;

  localparam logic [13:0] OP_ADD = 14'd1 << ALU_ADD;
  localparam logic [13:0] OP_SUB = 14'd1 << ALU_SUB;
  localparam logic [13:0] OP_AND = 14'd1 << ALU_AND;
  localparam logic [13:0] OP_OR  = 14'd1 << ALU_OR;
  localparam logic [13:0] OP_XOR = 14'd1 << ALU_XOR;

  logic         clk = 1'b0;
  logic         rst, flush, wb_ready, wb_valid;
  logic [1:0]   req_valid, req_ready;
  logic [27:0]  req_op;
  logic [127:0] req_src0, req_src1;
  logic [11:0]  req_tag;
  logic [13:0]  alu_op;
  logic [63:0]  alu_src0, alu_src1, alu_result, wb_data;
  logic [0:0]   wb_id;
  logic [5:0]   wb_tag;

  logic [13:0]  t_op   [2];
  logic [63:0]  t_a    [2];
  logic [63:0]  t_b    [2];
  logic [5:0]   t_tag  [2];

  assign req_op   = {t_op[1], t_op[0]};
  assign req_src0 = {t_a[1], t_a[0]};
  assign req_src1 = {t_b[1], t_b[0]};
  assign req_tag  = {t_tag[1], t_tag[0]};

  always #5 clk = ~clk;

  exu_alu_arb dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src0(req_src0), .req_src1(req_src1), .req_tag(req_tag),
    .alu_op(alu_op), .alu_src0(alu_src0), .alu_src1(alu_src1), .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_id(wb_id), .wb_tag(wb_tag), .wb_data(wb_data)
  );

  typedef struct {
    logic        id;
    logic [5:0]  tag;
    logic [63:0] data;
  } ent_t;

  typedef struct {
    bit          fl, wr;
    logic [1:0]  v;
    logic [13:0] o0;
    logic [63:0] a0, b0;
    logic [5:0]  t0;
    logic [13:0] o1;
    logic [63:0] a1, b1;
    logic [5:0]  t1;
    logic [1:0]  e_rdy;
    logic [13:0] e_op;
    bit          e_wbv;
    logic        e_id;
    logic [5:0]  e_tag;
    logic [63:0] e_data;
  } vec_t;

  vec_t  vt[$];
  ent_t  m_q[$];
  ent_t  m_s1;
  bit    m_s1v;
  int    m_rr;
  int    n_assert = 0;
  int    n_fail   = 0;

  logic [13:0] cap_op;
  logic [63:0] cap_a, cap_b;
  logic [1:0]  obs_ready;
  logic [13:0] obs_op;
  logic        obs_wbv, obs_id;
  logic [5:0]  obs_tag;
  logic [63:0] obs_data;

  function automatic logic [63:0] alu_eval(logic [13:0] op, logic [63:0] a, logic [63:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return a ^ {b[31:0], b[63:32]};
    endcase
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_s1v = 0;
    m_rr  = 0;
  endtask

  task automatic row(bit fl, bit wr, logic [1:0] v,
                     logic [13:0] o0, logic [63:0] a0, logic [63:0] b0, logic [5:0] t0,
                     logic [13:0] o1, logic [63:0] a1, logic [63:0] b1, logic [5:0] t1,
                     logic [1:0] e_rdy, logic [13:0] e_op, bit e_wbv,
                     logic e_id, logic [5:0] e_tag, logic [63:0] e_data);
    vec_t r;
    r.fl = fl; r.wr = wr; r.v = v;
    r.o0 = o0; r.a0 = a0; r.b0 = b0; r.t0 = t0;
    r.o1 = o1; r.a1 = a1; r.b1 = b1; r.t1 = t1;
    r.e_rdy = e_rdy; r.e_op = e_op; r.e_wbv = e_wbv;
    r.e_id = e_id; r.e_tag = e_tag; r.e_data = e_data;
    vt.push_back(r);
  endtask

  // Inputs are already applied at posedge+1; checks at posedge+3, then advance one clock.
  task automatic run_cycle();
    int   g;
    bit   e_wbv, e_pop, e_can, e_xfer;
    int   occ;
    ent_t h;
    #2;
    e_wbv = (m_q.size() != 0);
    e_pop = e_wbv && wb_ready;
    occ   = m_q.size() + int'(m_s1v) - int'(e_pop);
    e_can = !flush && (occ < 2);
    g = -1;
    for (int k = 0; k < 2; k++) begin
      int idx;
      idx = (m_rr + k) % 2;
      if (g < 0 && req_valid[idx]) g = idx;
    end
    e_xfer = e_can && (g >= 0);

    chk("req_ready", req_ready, e_xfer ? (2'b01 << g) : 2'b00);
    chk("alu_op",    alu_op,    e_xfer ? t_op[g] : 14'd0);
    chk("alu_src0",  alu_src0,  e_xfer ? t_a[g]  : 64'd0);
    chk("alu_src1",  alu_src1,  e_xfer ? t_b[g]  : 64'd0);
    chk("wb_valid",  wb_valid,  e_wbv);
    if (e_wbv) begin
      h = m_q[0];
      chk("wb_id",   wb_id,   h.id);
      chk("wb_tag",  wb_tag,  h.tag);
      chk("wb_data", wb_data, h.data);
    end
    if (wb_valid && wb_ready && !flush)
      $display("wb id=%0d tag=%0h data=%0h t=%0t", wb_id, wb_tag, wb_data, $time);

    obs_ready = req_ready; obs_op = alu_op; obs_wbv = wb_valid;
    obs_id = wb_id; obs_tag = wb_tag; obs_data = wb_data;
    cap_op = alu_op; cap_a = alu_src0; cap_b = alu_src1;

    if (flush) begin
      m_q.delete();
      m_s1v = 0;
    end else begin
      if (e_pop) void'(m_q.pop_front());
      if (m_s1v) m_q.push_back(m_s1);
      m_s1v = e_xfer;
      if (e_xfer) begin
        m_s1.id   = 1'(g);
        m_s1.tag  = t_tag[g];
        m_s1.data = alu_eval(t_op[g], t_a[g], t_b[g]);
        m_rr = (g + 1) % 2;
      end
    end
    @(posedge clk);
    #1;
    alu_result = alu_eval(cap_op, cap_a, cap_b);
  endtask

  task automatic set_port(int p, logic [13:0] op, logic [63:0] a, logic [63:0] b, logic [5:0] tg);
    t_op[p] = op; t_a[p] = a; t_b[p] = b; t_tag[p] = tg;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; wb_ready = 1'b0; req_valid = 2'b00; alu_result = '0;
    for (int p = 0; p < 2; p++) set_port(p, 14'd0, 64'd0, 64'd0, 6'd0);

    // single op, unit latency to writeback
    row(0,1,2'b01, OP_ADD,5,7,6'h03, 0,0,0,0,       2'b01,OP_ADD,0,0,0,0);
    row(0,1,2'b00, 0,0,0,0, 0,0,0,0,                2'b00,0,0,0,0,0);
    row(0,1,2'b00, 0,0,0,0, 0,0,0,0,                2'b00,0,1,0,6'h03,12);
    // port 1 subtract wrapping to all ones
    row(0,1,2'b10, 0,0,0,0, OP_SUB,0,1,6'h3F,       2'b10,OP_SUB,0,0,0,0);
    row(0,1,2'b00, 0,0,0,0, 0,0,0,0,                2'b00,0,0,0,0,0);
    row(0,1,2'b00, 0,0,0,0, 0,0,0,0,                2'b00,0,1,1,6'h3F,64'hFFFF_FFFF_FFFF_FFFF);
    // contention alternates grants, one result per cycle
    row(0,1,2'b11, OP_ADD,10,20,6'h01, OP_ADD,100,1,6'h02, 2'b01,OP_ADD,0,0,0,0);
    row(0,1,2'b11, OP_ADD,10,20,6'h01, OP_ADD,100,1,6'h02, 2'b10,OP_ADD,0,0,0,0);
    row(0,1,2'b11, OP_ADD,10,20,6'h01, OP_ADD,100,1,6'h02, 2'b01,OP_ADD,1,0,6'h01,30);
    row(0,1,2'b11, OP_ADD,10,20,6'h01, OP_ADD,100,1,6'h02, 2'b10,OP_ADD,1,1,6'h02,101);
    row(0,1,2'b00, 0,0,0,0, 0,0,0,0,                2'b00,0,1,0,6'h01,30);
    row(0,1,2'b00, 0,0,0,0, 0,0,0,0,                2'b00,0,1,1,6'h02,101);
    row(0,1,2'b00, 0,0,0,0, 0,0,0,0,                2'b00,0,0,0,0,0);
    // back-pressure: only two accepted, third issues on the first pop
    row(0,0,2'b01, OP_ADD,1,1,6'h04, 0,0,0,0,       2'b01,OP_ADD,0,0,0,0);
    row(0,0,2'b01, OP_ADD,2,2,6'h05, 0,0,0,0,       2'b01,OP_ADD,0,0,0,0);
    row(0,0,2'b01, OP_ADD,3,3,6'h06, 0,0,0,0,       2'b00,0,1,0,6'h04,2);
    row(0,0,2'b01, OP_ADD,3,3,6'h06, 0,0,0,0,       2'b00,0,1,0,6'h04,2);
    row(0,1,2'b01, OP_ADD,3,3,6'h06, 0,0,0,0,       2'b01,OP_ADD,1,0,6'h04,2);
    row(0,1,2'b00, 0,0,0,0, 0,0,0,0,                2'b00,0,1,0,6'h05,4);
    row(0,1,2'b00, 0,0,0,0, 0,0,0,0,                2'b00,0,1,0,6'h06,6);
    row(0,1,2'b00, 0,0,0,0, 0,0,0,0,                2'b00,0,0,0,0,0);

    // reset state, including a valid request held during reset
    @(posedge clk); #1;
    req_valid = 2'b11;
    set_port(0, OP_ADD, 64'd9, 64'd9, 6'h01);
    set_port(1, OP_ADD, 64'd8, 64'd8, 6'h02);
    #2;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_wb_valid",  wb_valid,  1'b0);
    chk("rst_alu_op",    alu_op,    14'd0);
    chk("rst_alu_src0",  alu_src0,  64'd0);
    rst = 1'b0;
    req_valid = 2'b00;
    @(posedge clk); #1;
    model_reset();

    foreach (vt[i]) begin
      flush = vt[i].fl; wb_ready = vt[i].wr; req_valid = vt[i].v;
      set_port(0, vt[i].o0, vt[i].a0, vt[i].b0, vt[i].t0);
      set_port(1, vt[i].o1, vt[i].a1, vt[i].b1, vt[i].t1);
      run_cycle();
      chk($sformatf("vec%0d_ready", i), obs_ready, vt[i].e_rdy);
      chk($sformatf("vec%0d_alu_op", i), obs_op, vt[i].e_op);
      chk($sformatf("vec%0d_wb_valid", i), obs_wbv, vt[i].e_wbv);
      if (vt[i].e_wbv) begin
        chk($sformatf("vec%0d_wb_id", i), obs_id, vt[i].e_id);
        chk($sformatf("vec%0d_wb_tag", i), obs_tag, vt[i].e_tag);
        chk($sformatf("vec%0d_wb_data", i), obs_data, vt[i].e_data);
      end
    end

    // flush with a queued result and an op in the capture stage
    flush = 1'b0; wb_ready = 1'b0; req_valid = 2'b01;
    set_port(0, OP_ADD, 64'd7, 64'd8, 6'h0A);
    run_cycle();
    set_port(0, OP_ADD, 64'd7, 64'd9, 6'h0B);
    run_cycle();
    flush = 1'b1; req_valid = 2'b11;
    set_port(1, OP_XOR, 64'hF0, 64'h0F, 6'h0C);
    run_cycle();
    chk("flush_ready", obs_ready, 2'b00);
    chk("flush_alu_op", obs_op, 14'd0);
    chk("flush_pre_wbv", obs_wbv, 1'b1);
    flush = 1'b0; req_valid = 2'b00; wb_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      run_cycle();
      chk($sformatf("flush_no_stale%0d", c), obs_wbv, 1'b0);
    end

    // asynchronous reset pulse between edges with a full queue
    wb_ready = 1'b0; req_valid = 2'b11;
    set_port(0, OP_AND, 64'hFF, 64'h3C, 6'h11);
    set_port(1, OP_OR,  64'h100, 64'h1, 6'h12);
    for (int c = 0; c < 3; c++) run_cycle();
    #2;
    chk("pre_rst_wb_valid", wb_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("arst_wb_valid",  wb_valid,  1'b0);
    chk("arst_req_ready", req_ready, 2'b00);
    chk("arst_alu_op",    alu_op,    14'd0);
    rst = 1'b0;
    model_reset();
    req_valid = 2'b00; wb_ready = 1'b1;
    @(posedge clk); #1;
    alu_result = '0;
    for (int c = 0; c < 3; c++) begin
      run_cycle();
      chk($sformatf("arst_no_stale%0d", c), obs_wbv, 1'b0);
    end

    // random traffic against the model
    for (int c = 0; c < 600; c++) begin
      flush     = ($urandom_range(0, 29) == 0);
      wb_ready  = (c % 100 < 70) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      req_valid = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++)
        set_port(p, 14'd1 << $urandom_range(0, 13), {$urandom, $urandom},
                 {$urandom, $urandom}, 6'($urandom_range(0, 63)));
      run_cycle();
    end

    flush = 1'b0; req_valid = 2'b00; wb_ready = 1'b1;
    for (int c = 0; c < 4; c++) run_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
